// File: rtl/dot_acc_pkg.sv
// Shared types, widths and the length-clamp helper for the dot-product accumulator.
package dot_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int PROD_W      = 64;
    localparam int DEF_ACC_W   = 72;
    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_LEN_W   = 5;

    // Zero-length requests become single-beat vectors; oversize ones saturate.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw == 0) begin
            return 1;
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Product-in / result-out handshake bundle between the multiplier, accumulator and consumer.
interface dot_product_accumulator_if
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) ();

    logic [PROD_W-1:0] prod_data;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  res_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_ovf;

    modport master (
        output prod_data,
        output prod_valid,
        input  prod_ready,
        input  res_data,
        input  res_valid,
        output res_ready,
        input  res_ovf
    );

    modport slave (
        input  prod_data,
        input  prod_valid,
        output prod_ready,
        output res_data,
        output res_valid,
        input  res_ready,
        output res_ovf
    );

endinterface

// File: rtl/dot_acc_beat_counter.sv
// Tracks the latched vector length and beat count, flagging the beat that completes a vector.
module dot_acc_beat_counter
    import dot_acc_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic             accum,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             last_beat
);

    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

    // In IDLE the incoming beat is the first one, so the live cfg_len decides.
    assign last_beat = accum ? ((cnt_reg + LEN_W'(1)) == len_reg)
                             : (len_clamped == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg <= '0;
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (accept) begin
            if (last_beat) begin
                cnt_reg <= '0;
            end else if (!accum) begin
                len_reg <= len_clamped;
                cnt_reg <= LEN_W'(1);
            end else begin
                cnt_reg <= cnt_reg + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums a programmable number of 64-bit products and hands each sum off through a one-deep output register.
module dot_product_accumulator
    import dot_acc_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic                      clear,
    dot_product_accumulator_if.slave  bus,
    output logic                      busy
);

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             ovf_reg;
    logic [ACC_W-1:0] res_data_reg;
    logic             res_valid_reg;
    logic             res_ovf_reg;
    logic             run_reg;

    logic             accept;
    logic             last_beat;
    logic             finish;
    logic             handoff;
    logic             in_accum;
    logic [ACC_W:0]   sum;
    logic             ovf_next;

    // Only the registered res_valid and the consumer's res_ready reach prod_ready.
    assign bus.prod_ready = run_reg & ~clear & (~res_valid_reg | bus.res_ready);
    assign accept         = bus.prod_valid & bus.prod_ready;
    assign handoff        = res_valid_reg & bus.res_ready;
    assign finish         = accept & last_beat;
    assign in_accum       = (state_reg == ACCUM);

    // acc_reg is zero in IDLE, so the same adder serves the first beat.
    assign sum      = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
    assign ovf_next = (in_accum & ovf_reg) | sum[ACC_W];

    dot_acc_beat_counter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_beat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (accept),
        .accum     (in_accum),
        .cfg_len   (cfg_len),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            res_data_reg  <= '0;
            res_valid_reg <= 1'b0;
            res_ovf_reg   <= 1'b0;
            run_reg       <= 1'b0;
        end else begin
            run_reg <= 1'b1;

            if (clear) begin
                state_reg <= IDLE;
                acc_reg   <= '0;
                ovf_reg   <= 1'b0;
            end else if (accept) begin
                if (last_beat) begin
                    state_reg <= IDLE;
                    acc_reg   <= '0;
                    ovf_reg   <= 1'b0;
                end else begin
                    state_reg <= ACCUM;
                    acc_reg   <= sum[ACC_W-1:0];
                    ovf_reg   <= ovf_next;
                end
            end

            // A finish overrides a simultaneous handoff so vectors can stream back to back.
            if (finish) begin
                res_data_reg  <= sum[ACC_W-1:0];
                res_ovf_reg   <= ovf_next;
                res_valid_reg <= 1'b1;
            end else if (handoff) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.res_data  = res_data_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_ovf   = res_ovf_reg;
    assign busy          = in_accum;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: a 72-bit instance plus a 64-bit instance for wrap checks.
module tb_dot_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] cfg_len = '0;
    logic       busy;
    logic       busy64;

    int total = 0;
    int bad   = 0;

    dot_product_accumulator_if #(.ACC_W(72)) bus ();
    dot_product_accumulator_if #(.ACC_W(64)) bus64 ();

    dot_product_accumulator #(.MAX_LEN(16), .ACC_W(72), .LEN_W(5)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .clear   (clear),
        .bus     (bus),
        .busy    (busy)
    );

    dot_product_accumulator #(.MAX_LEN(16), .ACC_W(64), .LEN_W(5)) u_dut64 (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .clear   (clear),
        .bus     (bus64),
        .busy    (busy64)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            $display("ok %s value=%0h", tag, obs);
        end else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.prod_valid   = 1'b0;
        bus.prod_data    = '0;
        bus.res_ready    = 1'b1;
        bus64.prod_valid = 1'b0;
        bus64.prod_data  = '0;
        bus64.res_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_prod_ready", bus.prod_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_ovf", bus.res_ovf, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", bus.prod_ready, 0);
        tick();
        check("ready_after_release", bus.prod_ready, 1);

        // Four-beat vector 1+2+3+4
        cfg_len = 5'd4;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd1;
        #1;
        check("t1_busy_b1", busy, 0);
        tick();
        check("t1_busy_b2", busy, 1);
        bus.prod_data = 64'd2;
        tick();
        bus.prod_data = 64'd3;
        tick();
        bus.prod_data = 64'd4;
        check("t1_busy_b4", busy, 1);
        check("t1_no_result_early", bus.res_valid, 0);
        tick();
        bus.prod_valid = 1'b0;
        check("t1_res_valid", bus.res_valid, 1);
        check("t1_res_data", bus.res_data, 10);
        check("t1_res_ovf", bus.res_ovf, 0);
        check("t1_busy_after", busy, 0);
        tick();
        check("t1_handoff", bus.res_valid, 0);

        // Back-to-back two-beat vectors
        cfg_len = 5'd2;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("t2_ready_b1", bus.prod_ready, 1);
        tick();
        check("t2_ready_b2", bus.prod_ready, 1);
        tick();
        check("t2_res_valid_a", bus.res_valid, 1);
        check("t2_res_data_a", bus.res_data, 128'h1_FFFF_FFFF_FFFF_FFFE);
        check("t2_ready_b3", bus.prod_ready, 1);
        bus.prod_data = 64'd5;
        tick();
        check("t2_between", bus.res_valid, 0);
        check("t2_ready_b4", bus.prod_ready, 1);
        bus.prod_data = 64'd7;
        tick();
        check("t2_res_valid_b", bus.res_valid, 1);
        check("t2_res_data_b", bus.res_data, 12);
        bus.prod_valid = 1'b0;
        tick();

        // Stalled result, then handoff and finish on the same edge
        bus.res_ready = 1'b0;
        cfg_len = 5'd1;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd7;
        #1;
        check("t3_ready_free", bus.prod_ready, 1);
        tick();
        check("t3_pending_valid", bus.res_valid, 1);
        check("t3_pending_data", bus.res_data, 7);
        bus.prod_data = 64'd8;
        check("t3_ready_stalled", bus.prod_ready, 0);
        tick();
        check("t3_data_stable", bus.res_data, 7);
        check("t3_valid_stable", bus.res_valid, 1);
        bus.res_ready = 1'b1;
        #1;
        check("t3_ready_passthru", bus.prod_ready, 1);
        tick();
        check("t3_swap_valid", bus.res_valid, 1);
        check("t3_swap_data", bus.res_data, 8);
        bus.prod_valid = 1'b0;
        tick();
        check("t3_drained", bus.res_valid, 0);

        // Three ones with no consumer, then the next vector is blocked
        bus.res_ready = 1'b0;
        cfg_len = 5'd3;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd1;
        tick();
        tick();
        check("t4_ready_b3", bus.prod_ready, 1);
        tick();
        check("t4_res_data", bus.res_data, 3);
        check("t4_ready_blocked", bus.prod_ready, 0);
        tick();
        check("t4_not_accepted", busy, 0);
        bus.res_ready = 1'b1;
        tick();
        check("t4_handed_off", bus.res_valid, 0);
        check("t4_new_vector", busy, 1);
        bus.prod_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_cleared", busy, 0);

        // 64-bit accumulator wraps
        cfg_len = 5'd2;
        bus64.prod_valid = 1'b1;
        bus64.prod_data = 64'h8000_0000_0000_0000;
        tick();
        tick();
        check("t5_wrap_valid", bus64.res_valid, 1);
        check("t5_wrap_data", bus64.res_data, 0);
        check("t5_wrap_ovf", bus64.res_ovf, 1);
        bus64.prod_data = 64'd1;
        tick();
        tick();
        check("t5_nowrap_data", bus64.res_data, 2);
        check("t5_nowrap_ovf", bus64.res_ovf, 0);
        bus64.prod_valid = 1'b0;
        tick();

        // Length clamps; mid-vector cfg_len change ignored
        cfg_len = 5'd0;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd9;
        tick();
        check("t6_len0_valid", bus.res_valid, 1);
        check("t6_len0_data", bus.res_data, 9);
        cfg_len = 5'd31;
        bus.prod_data = 64'd1;
        tick();
        cfg_len = 5'd1;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check("t6_after15_valid", bus.res_valid, 0);
        check("t6_after15_busy", busy, 1);
        tick();
        check("t6_len16_valid", bus.res_valid, 1);
        check("t6_len16_data", bus.res_data, 16);
        bus.prod_valid = 1'b0;
        tick();

        // Clear after two of four beats
        cfg_len = 5'd4;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd5;
        tick();
        tick();
        bus.prod_data = 64'd100;
        clear = 1'b1;
        #1;
        check("t7_ready_in_clear", bus.prod_ready, 0);
        check("t7_busy_before_clear", busy, 1);
        tick();
        check("t7_busy_after_clear", busy, 0);
        clear = 1'b0;
        bus.prod_data = 64'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("t7_res_valid", bus.res_valid, 1);
        check("t7_res_data", bus.res_data, 12);
        bus.prod_valid = 1'b0;
        tick();

        // Asynchronous reset mid-vector
        cfg_len = 5'd1;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd9;
        tick();
        cfg_len = 5'd4;
        bus.prod_data = 64'd1;
        tick();
        tick();
        bus.prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t8_rst_busy", busy, 0);
        check("t8_rst_ready", bus.prod_ready, 0);
        check("t8_rst_valid", bus.res_valid, 0);
        check("t8_rst_data", bus.res_data, 0);
        check("t8_rst_ovf", bus.res_ovf, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t8_ready_after", bus.prod_ready, 1);
        check("t8_busy_after", busy, 0);
        cfg_len = 5'd2;
        bus.prod_valid = 1'b1;
        bus.prod_data = 64'd4;
        tick();
        bus.prod_data = 64'd6;
        tick();
        check("t8_fresh_data", bus.res_data, 10);
        bus.prod_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
